// File: rtl/uart_rx_loader_pkg.sv
// Shared encodings for the UART program loader: FSM states, error codes
// and the default frame header byte.
package uart_rx_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_LEN  = 3'd1,
        LDR_LO   = 3'd2,
        LDR_HI   = 3'd3,
        LDR_CSUM = 3'd4
    } ldr_state_t;

    localparam logic [1:0] LDR_ERR_CSUM    = 2'd1;
    localparam logic [1:0] LDR_ERR_TIMEOUT = 2'd2;

    localparam logic [7:0] LDR_HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_loader_edge_sync.sv
// Two-flop synchronizer for a level from another clock domain, with a
// one-cycle pulse on each synchronized rising edge.
module edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/uart_rx_loader.sv
// Assembles framed 16-bit words from the UART byte stream into memory
// writes: header, length N, N little-endian words, XOR checksum.
import uart_rx_loader_pkg::*;

module uart_rx_loader #(
    parameter int                ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter logic [7:0]        HEADER         = LDR_HEADER_DEFAULT,
    parameter int                TIMEOUT_CYCLES = 260000
) (
    input  logic              clk_25M,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic rx_rise;

    edge_sync u_rx_sync (
        .clk_i   (clk_25M),
        .rst_ni  (reset_n),
        .async_i (rx_ready),
        .rise_o  (rx_rise)
    );

    logic [7:0] byte_q;
    logic       byte_vld_q;

    // rx_data is stable while rx_ready is high, so sampling on the edge pulse is safe
    always_ff @(posedge clk_25M or negedge reset_n) begin
        if (!reset_n) begin
            byte_q     <= 8'h00;
            byte_vld_q <= 1'b0;
        end else begin
            if (rx_rise) begin
                byte_q <= rx_data;
            end
            byte_vld_q <= rx_rise;
        end
    end

    ldr_state_t        state_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  tmo_d;
    logic              tmo_hit;

    // A byte arriving on the terminal-count cycle takes priority over the timeout
    always_comb begin
        tmo_d   = tmo_q + TMO_W'(1);
        tmo_hit = 1'b0;
        if (byte_vld_q || state_q == LDR_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d   = tmo_q;
            tmo_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_25M or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_data_q;
    logic              mem_we_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic [7:0]        word_cnt_q;
    logic [7:0]        csum_q;
    logic [7:0]        lo_q;

    always_ff @(posedge clk_25M or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LDR_IDLE;
            mem_addr_q <= BASE_ADDR;
            mem_data_q <= 16'h0000;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            word_cnt_q <= 8'h00;
            csum_q     <= 8'h00;
            lo_q       <= 8'h00;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;

            // Address stays put for the strobe cycle and advances right after
            if (mem_we_q) begin
                mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end

            if (tmo_hit) begin
                err_q      <= 1'b1;
                err_code_q <= LDR_ERR_TIMEOUT;
                state_q    <= LDR_IDLE;
            end else if (byte_vld_q) begin
                case (state_q)
                    LDR_IDLE: begin
                        if (byte_q == HEADER) begin
                            state_q <= LDR_LEN;
                        end
                    end
                    LDR_LEN: begin
                        // A length of 0 wraps through the 8-bit counter, giving 256 words
                        word_cnt_q <= byte_q;
                        csum_q     <= byte_q;
                        mem_addr_q <= BASE_ADDR;
                        state_q    <= LDR_LO;
                    end
                    LDR_LO: begin
                        lo_q    <= byte_q;
                        csum_q  <= csum_q ^ byte_q;
                        state_q <= LDR_HI;
                    end
                    LDR_HI: begin
                        mem_data_q <= {byte_q, lo_q};
                        mem_we_q   <= 1'b1;
                        csum_q     <= csum_q ^ byte_q;
                        word_cnt_q <= word_cnt_q - 8'd1;
                        state_q    <= (word_cnt_q == 8'd1) ? LDR_CSUM : LDR_LO;
                    end
                    LDR_CSUM: begin
                        if (byte_q == csum_q) begin
                            done_q <= 1'b1;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= LDR_ERR_CSUM;
                        end
                        state_q <= LDR_IDLE;
                    end
                    default: begin
                        state_q <= LDR_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign busy     = (state_q != LDR_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader: table of frames plus hand-written
// sequences for timeout, held rx_ready and reset mid-frame.
module tb_uart_rx_loader;

    localparam int TMO = 3000;

    logic        clk_25M;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    uart_rx_loader #(
        .ADDR_W         (16),
        .BASE_ADDR      (16'h0000),
        .HEADER         (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_25M  (clk_25M),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    initial clk_25M = 1'b0;
    always #20 clk_25M = ~clk_25M;

    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    int          done_cnt    = 0;
    int          err_cnt     = 0;
    int          overlap_cnt = 0;
    logic [1:0]  last_code   = 2'd0;

    always @(negedge clk_25M) begin
        if (mem_we) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_data);
        end
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            last_code = err_code;
        end
        if ((done && err) || (mem_we && (done || err))) overlap_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(posedge clk_25M);
        #1;
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (hold) @(posedge clk_25M);
        #1;
        rx_ready = 1'b0;
        repeat (gap) @(posedge clk_25M);
        #1;
    endtask

    typedef struct {
        string            name;
        logic [95:0]      bytes;
        int               nb;
        logic [3:0][15:0] w;
        int               nw;
        int               exp_done;
        int               exp_err;
        logic [1:0]       exp_code;
    } vec_t;

    vec_t vecs[4];

    task automatic run_frame(input vec_t v, input int hold);
        int w0;
        int d0;
        int e0;
        logic [7:0] b;
        w0 = wr_data_log.size();
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < v.nb; i++) begin
            b = v.bytes[95 - 8*i -: 8];
            send_byte(b, hold, 6);
        end
        repeat (10) @(posedge clk_25M);
        #1;
        check({v.name, " nwrites"}, 32'(wr_data_log.size() - w0), 32'(v.nw));
        for (int k = 0; k < v.nw; k++) begin
            if (w0 + k < wr_data_log.size()) begin
                check({v.name, " addr"}, 32'(wr_addr_log[w0 + k]), 32'(k));
                check({v.name, " data"}, 32'(wr_data_log[w0 + k]), 32'(v.w[k]));
            end
        end
        check({v.name, " done"}, 32'(done_cnt - d0), 32'(v.exp_done));
        check({v.name, " err"}, 32'(err_cnt - e0), 32'(v.exp_err));
        if (v.exp_err != 0) check({v.name, " err_code"}, 32'(last_code), 32'(v.exp_code));
        check({v.name, " busy idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int w0;
        int d0;
        int e0;

        vecs[0] = '{"good2", 96'hA502341278560A_0000000000, 7,
                    {16'h0, 16'h0, 16'h5678, 16'h1234}, 2, 1, 0, 2'd0};
        vecs[1] = '{"badcsum", 96'hA502341278560B_0000000000, 7,
                    {16'h0, 16'h0, 16'h5678, 16'h1234}, 2, 0, 1, 2'd1};
        vecs[2] = '{"garbage1", 96'h00FF3CA501CDAB67_00000000, 8,
                    {16'h0, 16'h0, 16'h0, 16'hABCD}, 1, 1, 0, 2'd0};
        vecs[3] = '{"hdrdata3", 96'hA5030100A5A5FFFF02_000000, 9,
                    {16'h0, 16'hFFFF, 16'hA5A5, 16'h0001}, 3, 1, 0, 2'd0};

        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk_25M);
        #1;
        check("reset outputs", {mem_addr, mem_data}, 32'h0);
        check("reset flags", {27'd0, mem_we, busy, done, err, err_code == 2'd0}, 32'h1);
        reset_n = 1'b1;
        repeat (3) @(posedge clk_25M);
        #1;

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], 4);
        end

        // Inter-byte timeout after one full word of a 3-word frame
        w0 = wr_data_log.size();
        e0 = err_cnt;
        send_byte(8'hA5, 4, 6);
        check("tmo busy", 32'(busy), 32'd1);
        send_byte(8'h03, 4, 6);
        send_byte(8'h11, 4, 6);
        send_byte(8'h22, 4, 6);
        check("tmo write", 32'(wr_data_log.size() - w0), 32'd1);
        if (wr_data_log.size() > w0) check("tmo data", 32'(wr_data_log[w0]), 32'h2211);
        repeat (TMO - 100) @(posedge clk_25M);
        #1;
        check("tmo not early", 32'(err_cnt - e0), 32'd0);
        repeat (200) @(posedge clk_25M);
        #1;
        check("tmo err", 32'(err_cnt - e0), 32'd1);
        check("tmo code", 32'(last_code), 32'd2);
        check("tmo busy drop", 32'(busy), 32'd0);
        run_frame(vecs[0], 4);

        // rx_ready held high: one byte event per rise
        run_frame(vecs[0], 1000);

        // Reset in the middle of a frame
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5, 4, 6);
        send_byte(8'h02, 4, 6);
        send_byte(8'h34, 4, 6);
        check("mid busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset outs", {14'd0, mem_addr, mem_we, done, err == 1'b0, err_code == 2'd0}, 32'h3);
        repeat (2) @(posedge clk_25M);
        #1;
        reset_n = 1'b1;
        w0 = wr_data_log.size();
        send_byte(8'h12, 4, 6);
        send_byte(8'h78, 4, 6);
        send_byte(8'h56, 4, 6);
        send_byte(8'h0A, 4, 6);
        repeat (10) @(posedge clk_25M);
        #1;
        check("post reset no write", 32'(wr_data_log.size() - w0), 32'd0);
        check("post reset no pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        run_frame(vecs[0], 4);

        check("no overlap pulses", 32'(overlap_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_loader.md
Name: uart_rx_loader

Overview:
- Consumes the byte stream from the UART receiver (data/data_ready pair) and assembles framed 16-bit words into memory writes for program loading.
- Frame: header 0xA5, length byte N, then N words as little-endian byte pairs, then an XOR checksum byte.
- Sits between the UART receiver and the memory write port of the little computer.
- Reports completion or error with single-cycle status pulses.

Parameters:
- ADDR_W, 16, width of mem_addr.
- BASE_ADDR, 0, address of the first word written in every frame.
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYCLES, 260000, max clk_25M cycles allowed between bytes inside a frame (about 10 byte times at 9600 baud).

Ports:
- clk_25M  input  1  system clock, 25 MHz.
- reset_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte; stable while rx_ready is high.
- rx_ready  input  1  level from the receiver, generated in its divided clock domain; a rising edge means a new byte.
- mem_addr  output  ADDR_W  write address.
- mem_data  output  16  write data.
- mem_we  output  1  one-cycle write strobe; memory always accepts.
- busy  output  1  high while a frame is in progress (any state except IDLE).
- done  output  1  one-cycle pulse: frame finished, checksum good.
- err  output  1  one-cycle pulse: frame aborted or checksum bad.
- err_code  output  2  valid with err: 1 = checksum mismatch, 2 = inter-byte timeout; holds its value until the next err.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; mem_addr = BASE_ADDR; synchronizer, counters and checksum cleared.
- Byte detect: rx_ready passes through a 2-flop synchronizer; a third flop gives rising-edge detect.
  - On the edge cycle, rx_data is captured into byte_q.
  - A "byte" event is consumed the next cycle, so latency is 4 clk_25M cycles from the rx_ready rise.
  - rx_ready held high produces exactly one byte event.
- States:
  - IDLE: a byte equal to HEADER goes to LEN; any other byte is ignored silently with no err.
  - LEN: the byte loads word_cnt (0 means 256) and seeds csum = byte; mem_addr set to BASE_ADDR; go to LO.
  - LO: lo_q = byte; csum ^= byte; go to HI.
  - HI:
    - mem_data = {byte, lo_q}; mem_we = 1 for one cycle; csum ^= byte; word_cnt decrements.
    - mem_addr holds the written address during the strobe, then increments the following cycle.
    - Goes to CSUM if word_cnt was 1, else to LO.
  - CSUM:
    - If byte == csum: done = 1.
    - Otherwise: err = 1 and err_code = 1.
    - Go to IDLE either way.
    - Words already written are not rolled back; err informs software.
- Timeout: a counter clears on every byte event and in IDLE, and increments otherwise.
  - Reaching TIMEOUT_CYCLES in any non-IDLE state causes err = 1, err_code = 2, and a return to IDLE.
  - A byte event on the same cycle as terminal count wins; no timeout is raised.
- Address wrap: mem_addr wraps modulo 2^ADDR_W with no error.
- Header byte value inside a frame is treated as data; there is no resync within a frame.
- Reset mid-frame abandons the frame with no err or done pulse; the next frame needs a new header.
- done and err are never asserted together. mem_we never coincides with done or err.

Decomposition:
- Shared package/defines file holds:
  - state encodings LDR_IDLE, LDR_LEN, LDR_LO, LDR_HI, LDR_CSUM;
  - error codes LDR_ERR_CSUM = 1 and LDR_ERR_TIMEOUT = 2;
  - the default HEADER constant.
- One sub-module, edge_sync: 2-flop synchronizer plus rising-edge pulse, with async active-low reset. It is reusable for other cross-domain strobes.

Test Plan:
- Frame A5 02 34 12 78 56 with checksum 02^34^12^78^56 = 0x0A:
  - writes 0x1234 at addr 0, then 0x5678 at addr 1;
  - done pulses once after the checksum byte; err stays 0.
- Same frame with checksum byte 0x0B: both writes occur, then err = 1 with err_code = 1 and no done.
- Bytes 00 FF 3C, then a valid 1-word frame A5 01 CD AB (csum 01^CD^AB = 0x67):
  - the leading bytes are ignored;
  - one write of 0xABCD at BASE_ADDR, then done.
- A5 03 11 22, then silence for TIMEOUT_CYCLES: err with err_code = 2, busy drops; a following valid frame completes normally.
- rx_ready held high for 1000 cycles per byte: exactly one byte event per rise, so the correct frame gives exactly 2 mem_we pulses for N = 2.
- reset_n pulsed low mid-frame after A5 02 34: outputs go to 0 immediately; no done or err; a subsequent full frame writes from BASE_ADDR.
